// File: rtl/seg_digit_driver.sv
// Segment-data stage: maps the scanner's active-low digit select onto the 8-bit segment bus,
// with a double-buffered 6-digit BCD display, leading-zero blanking, decimal points and blink.
module seg_digit_driver #(
    parameter logic [24:0] BLINK_DIV = 25'd12_499_999,
    parameter logic        LZB_EN    = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [5:0]  sel,
    input  logic        load,
    input  logic [23:0] value_bcd,
    input  logic [5:0]  dp_mask,
    input  logic [5:0]  blink_mask,
    output logic        pending,
    output logic [7:0]  seg
);

    localparam int unsigned NDIG = 6;
    localparam int unsigned DW   = 4;
    localparam int unsigned VW   = NDIG * DW;
    localparam int unsigned CW   = 25;
    localparam int unsigned SW   = 8;
    localparam logic [NDIG-1:0] SEL_MSD = 6'b011111;

    typedef struct packed {
        logic [VW-1:0]   value;
        logic [NDIG-1:0] dp;
        logic [NDIG-1:0] blink;
    } disp_buf_t;

    disp_buf_t       active_q, active_d;
    disp_buf_t       shadow_q, shadow_d;
    disp_buf_t       in_buf_c;
    logic            pending_q, pending_d;
    logic [NDIG-1:0] sel_q, sel_d;
    logic [CW-1:0]   blink_cnt_q, blink_cnt_d;
    logic            phase_q, phase_d;
    logic [SW-1:0]   seg_q, seg_d;

    logic            boundary_c;
    logic [NDIG-1:0] blank_c;
    logic            lz_run_c;
    logic [2:0]      low_cnt_c;
    logic [DW-1:0]   cur_digit_c;
    logic            cur_dp_c;
    logic            cur_blink_c;
    logic            cur_blank_c;
    logic [6:0]      pat_c;

    // Buffer transfer and blink timebase
    always_comb begin
        in_buf_c    = '{value: value_bcd, dp: dp_mask, blink: blink_mask};
        boundary_c  = (sel == SEL_MSD) && (sel_q != SEL_MSD);
        active_d    = active_q;
        shadow_d    = shadow_q;
        pending_d   = pending_q;
        sel_d       = sel;
        blink_cnt_d = blink_cnt_q + CW'(1);
        phase_d     = phase_q;

        if (load) begin
            shadow_d = in_buf_c;
            if (boundary_c) begin
                active_d  = in_buf_c;
                pending_d = 1'b0;
            end else begin
                pending_d = 1'b1;
            end
        end else if (boundary_c && pending_q) begin
            active_d  = shadow_q;
            pending_d = 1'b0;
        end

        if (blink_cnt_q == BLINK_DIV - CW'(1)) begin
            blink_cnt_d = '0;
            phase_d     = ~phase_q;
        end
    end

    // Leading-zero run from the MSD down; a lit dp ends the run
    always_comb begin
        blank_c  = '0;
        lz_run_c = LZB_EN;
        for (int i = NDIG - 1; i >= 0; i--) begin
            lz_run_c   = lz_run_c && (active_q.value[i*DW +: DW] == DW'(0)) && !active_q.dp[i];
            blank_c[i] = lz_run_c;
        end
        blank_c[0] = 1'b0;
    end

    // Digit pick, decode and dark conditions
    always_comb begin
        low_cnt_c   = '0;
        cur_digit_c = '0;
        cur_dp_c    = 1'b0;
        cur_blink_c = 1'b0;
        cur_blank_c = 1'b0;
        for (int i = 0; i < NDIG; i++) begin
            if (!sel[i]) begin
                low_cnt_c   = low_cnt_c + 3'd1;
                cur_digit_c = active_q.value[i*DW +: DW];
                cur_dp_c    = active_q.dp[i];
                cur_blink_c = active_q.blink[i];
                cur_blank_c = blank_c[i];
            end
        end

        case (cur_digit_c)
            4'd0:    pat_c = 7'h40;
            4'd1:    pat_c = 7'h79;
            4'd2:    pat_c = 7'h24;
            4'd3:    pat_c = 7'h30;
            4'd4:    pat_c = 7'h19;
            4'd5:    pat_c = 7'h12;
            4'd6:    pat_c = 7'h02;
            4'd7:    pat_c = 7'h78;
            4'd8:    pat_c = 7'h00;
            4'd9:    pat_c = 7'h10;
            default: pat_c = 7'h3F;
        endcase

        seg_d = 8'hFF;
        if ((low_cnt_c == 3'd1) && !(cur_blink_c && phase_q) && !cur_blank_c) begin
            seg_d = {~cur_dp_c, pat_c};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            active_q    <= '0;
            shadow_q    <= '0;
            pending_q   <= 1'b0;
            sel_q       <= '1;
            blink_cnt_q <= '0;
            phase_q     <= 1'b0;
            seg_q       <= 8'hFF;
        end else begin
            active_q    <= active_d;
            shadow_q    <= shadow_d;
            pending_q   <= pending_d;
            sel_q       <= sel_d;
            blink_cnt_q <= blink_cnt_d;
            phase_q     <= phase_d;
            seg_q       <= seg_d;
        end
    end

    assign pending = pending_q;
    assign seg     = seg_q;

endmodule
